uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: packet start marker.
REQ-002 SHALL have parameter OPERAND_BYTES, default 4: operand length in bytes (1-4).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000: inter-byte timeout in clocks.
REQ-004 SHALL have port i_clk, input, 1: single clock.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_rx_byte, input, 8: received byte from UART receiver.
REQ-007 SHALL have port i_rx_byte_valid, input, 1: one-cycle strobe qualifying i_rx_byte.
REQ-008 SHALL have port i_rx_err, input, 1: one-cycle receiver parity-error strobe.
REQ-009 SHALL have port o_cmd_valid, output, 1: command available.
REQ-010 SHALL have port i_cmd_ready, input, 1: consumer accepts command.
REQ-011 SHALL have port o_cmd_op, output, 8: command opcode.
REQ-012 SHALL have port o_cmd_data, output, 8*OPERAND_BYTES: operand, first received byte in MSBs.
REQ-013 SHALL have port o_pkt_err, output, 1: one-cycle packet-error pulse.
REQ-014 SHALL have port o_err_code, output, 2: 0 checksum, 1 bad opcode, 2 rx error, 3 timeout; valid with o_pkt_err.
REQ-015 SHALL have port o_overrun, output, 1: one-cycle pulse, good packet dropped.
REQ-016 SHALL have port o_err_cnt, output, 8: saturating count of o_pkt_err plus o_overrun pulses.

Function
REQ-017 SHALL implement FSM states IDLE, OPCODE, PAYLOAD, CHECK.
REQ-018 IDLE: SHALL move to OPCODE on a valid byte equal to SYNC_BYTE; all other bytes ignored.
REQ-019 OPCODE: valid byte 8'h01 (SINCOS) or 8'h02 (ATAN) SHALL be latched and FSM SHALL move to PAYLOAD; any other value SHALL pulse o_pkt_err with code 1 and return to IDLE.
REQ-020 PAYLOAD: SHALL shift in OPERAND_BYTES bytes MSB-first, then move to CHECK.
REQ-021 CHECK: SHALL compare the byte with the XOR of opcode and all operand bytes; on mismatch it SHALL pulse o_pkt_err with code 0; in both cases it SHALL return to IDLE.
REQ-022 On match, o_cmd_valid SHALL assert the cycle after the checksum strobe (latency 1) with o_cmd_op/o_cmd_data.
REQ-023 o_cmd_op/o_cmd_data SHALL hold stable while o_cmd_valid=1; o_cmd_valid SHALL deassert the cycle after o_cmd_valid&&i_cmd_ready.
REQ-024 A good packet completing while o_cmd_valid=1 and i_cmd_ready=0 SHALL be discarded, with o_overrun pulsed and the held command unchanged.
REQ-025 A good packet completing in the same cycle as the handshake SHALL load as the next command (no overrun, o_cmd_valid stays 1).
REQ-026 i_rx_err in any non-IDLE state SHALL abort to IDLE with o_pkt_err code 2; if coincident with i_rx_byte_valid, the error SHALL win and the byte SHALL be dropped; in IDLE it SHALL be ignored.
REQ-027 Parsing SHALL continue while a command is pending; the parser SHALL never backpressure the UART.
REQ-028 o_err_cnt SHALL increment by 1 per cycle with o_pkt_err or o_overrun and saturate at 255.

Reset
REQ-029 When i_rst=1 at a clock edge: FSM=IDLE, o_cmd_valid=0, o_cmd_op=0, o_cmd_data=0, o_pkt_err=0, o_err_code=0, o_overrun=0, o_err_cnt=0, timeout counter=0.
REQ-030 Reset mid-packet or with a command pending SHALL discard all state without error pulses.

Configuration
REQ-031 With macro UART_CMD_PARSER_TIMEOUT_EN defined, a counter SHALL clear on each valid byte and count while not IDLE; reaching TIMEOUT_CYCLES SHALL abort to IDLE with o_pkt_err code 3.
REQ-032 Without UART_CMD_PARSER_TIMEOUT_EN, no timeout logic SHALL exist and error code 3 SHALL never occur.

Structure
REQ-033 Package uart_cmd_pkg SHALL hold the parser state enum, opcode constants (OP_SINCOS=8'h01, OP_ATAN=8'h02) and error-code constants.
REQ-034 No sub-module is required; the timeout counter and checksum accumulator SHALL be inline.

Verification
REQ-035 Bytes A5,01,12,34,56,78,09 -> o_cmd_valid=1 one cycle after the 09 strobe, op=01, data=32'h12345678.
REQ-036 Same packet with checksum 0A -> o_pkt_err pulse, code 0, o_err_cnt=1, no o_cmd_valid.
REQ-037 A5,7F -> o_pkt_err code 1; following A5,02,00,00,00,01,03 -> cmd op=02, data=1.
REQ-038 i_cmd_ready=0; two good packets -> first held unchanged, o_overrun pulse on second; ready=1 -> one handshake, valid drops next cycle.
REQ-039 i_rx_err coincident with 3rd payload byte -> code 2, FSM IDLE; with TIMEOUT_CYCLES=50 and macro defined, A5 then idle 50 cycles -> code 3.
REQ-040 300 checksum errors -> o_err_cnt=255; i_rst mid-packet -> all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser: FSM states, opcodes, error codes.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OPCODE  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHECK   = 2'd3
   } parser_state_e;

   localparam logic [7:0] OP_SINCOS = 8'h01;
   localparam logic [7:0] OP_ATAN   = 8'h02;

   localparam logic [1:0] ERR_CHECKSUM = 2'd0;
   localparam logic [1:0] ERR_BAD_OP   = 2'd1;
   localparam logic [1:0] ERR_RX       = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   function automatic logic is_valid_op(input logic [7:0] op);
      return (op == OP_SINCOS) || (op == OP_ATAN);
   endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Byte-stream packet parser: SYNC, opcode, operand bytes (MSB first), XOR checksum -> one-deep command register.
// Optional inter-byte timeout enabled by defining UART_CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         OPERAND_BYTES  = 4,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [7:0]                 i_rx_byte,
   input  logic                       i_rx_byte_valid,
   input  logic                       i_rx_err,
   output logic                       o_cmd_valid,
   input  logic                       i_cmd_ready,
   output logic [7:0]                 o_cmd_op,
   output logic [8*OPERAND_BYTES-1:0] o_cmd_data,
   output logic                       o_pkt_err,
   output logic [1:0]                 o_err_code,
   output logic                       o_overrun,
   output logic [7:0]                 o_err_cnt
);

   localparam int DW  = 8*OPERAND_BYTES;
   localparam int BCW = $clog2(OPERAND_BYTES+1);

   if (OPERAND_BYTES < 1 || OPERAND_BYTES > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("uart_cmd_parser: OPERAND_BYTES must be 1-4 and TIMEOUT_CYCLES >= 2");
   end

   parser_state_e  state_q, state_d;
   logic [7:0]     op_q, op_d;
   logic [DW-1:0]  shift_q, shift_d;
   logic [DW+7:0]  shift_ext;
   logic [7:0]     csum_q, csum_d;
   logic [BCW-1:0] cnt_q, cnt_d;

   logic           cmd_valid_q, cmd_valid_d;
   logic [7:0]     cmd_op_q, cmd_op_d;
   logic [DW-1:0]  cmd_data_q, cmd_data_d;
   logic           pkt_err_q, pkt_err_d;
   logic [1:0]     err_code_q, err_code_d;
   logic           overrun_q, overrun_d;
   logic [7:0]     err_cnt_q, err_cnt_d;

   logic           abort;
   logic [1:0]     abort_code;
   logic           good_pkt;
   logic           fire;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;
   assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES-1));
`endif

   // Packet FSM; a receiver error outranks a coincident byte.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      shift_d    = shift_q;
      csum_d     = csum_q;
      cnt_d      = cnt_q;
      abort      = 1'b0;
      abort_code = ERR_CHECKSUM;
      good_pkt   = 1'b0;
      shift_ext  = {shift_q, i_rx_byte};
      if (state_q != ST_IDLE && i_rx_err) begin
         abort      = 1'b1;
         abort_code = ERR_RX;
         state_d    = ST_IDLE;
      end else if (i_rx_byte_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_rx_byte == SYNC_BYTE) state_d = ST_OPCODE;
            end
            ST_OPCODE: begin
               if (is_valid_op(i_rx_byte)) begin
                  op_d    = i_rx_byte;
                  csum_d  = i_rx_byte;
                  cnt_d   = '0;
                  state_d = ST_PAYLOAD;
               end else begin
                  abort      = 1'b1;
                  abort_code = ERR_BAD_OP;
                  state_d    = ST_IDLE;
               end
            end
            ST_PAYLOAD: begin
               shift_d = shift_ext[DW-1:0];
               csum_d  = csum_q ^ i_rx_byte;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == BCW'(OPERAND_BYTES-1)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
               state_d = ST_IDLE;
               if (i_rx_byte == csum_q) begin
                  good_pkt = 1'b1;
               end else begin
                  abort      = 1'b1;
                  abort_code = ERR_CHECKSUM;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      else if (tmo_hit) begin
         abort      = 1'b1;
         abort_code = ERR_TIMEOUT;
         state_d    = ST_IDLE;
      end
`endif
   end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
   always_comb begin
      tmo_d = tmo_q + 1'b1;
      if (state_d == ST_IDLE || i_rx_byte_valid) tmo_d = '0;
   end
`endif

   // A packet finishing on the handshake cycle refills the slot; otherwise a full slot drops it.
   always_comb begin
      fire        = cmd_valid_q && i_cmd_ready;
      cmd_valid_d = cmd_valid_q;
      cmd_op_d    = cmd_op_q;
      cmd_data_d  = cmd_data_q;
      overrun_d   = 1'b0;
      if (good_pkt) begin
         if (!cmd_valid_q || fire) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = op_q;
            cmd_data_d  = shift_q;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (fire) begin
         cmd_valid_d = 1'b0;
      end
      pkt_err_d  = abort;
      err_code_d = abort ? abort_code : err_code_q;
      err_cnt_d  = err_cnt_q;
      if ((abort || overrun_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         shift_q     <= '0;
         csum_q      <= '0;
         cnt_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= '0;
         cmd_data_q  <= '0;
         pkt_err_q   <= 1'b0;
         err_code_q  <= '0;
         overrun_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         shift_q     <= shift_d;
         csum_q      <= csum_d;
         cnt_q       <= cnt_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_op_q    <= cmd_op_d;
         cmd_data_q  <= cmd_data_d;
         pkt_err_q   <= pkt_err_d;
         err_code_q  <= err_code_d;
         overrun_q   <= overrun_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`endif

   assign o_cmd_valid = cmd_valid_q;
   assign o_cmd_op    = cmd_op_q;
   assign o_cmd_data  = cmd_data_q;
   assign o_pkt_err   = pkt_err_q;
   assign o_err_code  = err_code_q;
   assign o_overrun   = overrun_q;
   assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: packet-level reference model plus literal spot checks.
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   localparam int OB  = 4;
   localparam int TMO = 50;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_byte;
   logic        rx_valid, rx_err, ready;
   logic        o_cmd_valid, o_pkt_err, o_overrun;
   logic [7:0]  o_cmd_op, o_err_cnt;
   logic [31:0] o_cmd_data;
   logic [1:0]  o_err_code;

   int checks = 0;
   int errors = 0;
   bit go = 1'b0;

   always #5 clk = ~clk;

   uart_cmd_parser #(.SYNC_BYTE(8'hA5), .OPERAND_BYTES(OB), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx_byte(rx_byte), .i_rx_byte_valid(rx_valid),
      .i_rx_err(rx_err), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(ready),
      .o_cmd_op(o_cmd_op), .o_cmd_data(o_cmd_data), .o_pkt_err(o_pkt_err),
      .o_err_code(o_err_code), .o_overrun(o_overrun), .o_err_cnt(o_err_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: buffers the packet as a byte list and judges it when the checksum byte lands.
   byte unsigned m_buf[$];
   int          m_tmo = 0;
   bit          m_valid = 0, m_pkt_err = 0, m_overrun = 0;
   logic [7:0]  m_op = 0;
   logic [31:0] m_data = 0;
   logic [1:0]  m_code = 0;
   int          m_cnt = 0;

   always @(posedge clk) begin : model
      bit good, err, fire;
      logic [1:0]  code;
      logic [7:0]  x, p_op;
      logic [31:0] d;
      good = 0; err = 0; code = 0; x = 0; d = 0; p_op = 0;
      m_pkt_err = 0; m_overrun = 0;
      if (rst) begin
         m_buf.delete(); m_tmo = 0; m_valid = 0; m_op = 0; m_data = 0; m_code = 0; m_cnt = 0;
      end else begin
         if (m_buf.size() != 0 && rx_err) begin
            err = 1; code = 2; m_buf.delete();
         end else if (rx_valid) begin
            m_tmo = 0;
            if (m_buf.size() == 0) begin
               if (rx_byte == 8'hA5) m_buf.push_back(rx_byte);
            end else if (m_buf.size() == 1 && rx_byte != 8'h01 && rx_byte != 8'h02) begin
               err = 1; code = 1; m_buf.delete();
            end else if (m_buf.size() == OB + 2) begin
               for (int i = 1; i < m_buf.size(); i++) x = x ^ m_buf[i];
               for (int i = 2; i < m_buf.size(); i++) d = (d << 8) | {24'h0, m_buf[i]};
               p_op = m_buf[1];
               if (x == rx_byte) good = 1;
               else begin err = 1; code = 0; end
               m_buf.delete();
            end else begin
               m_buf.push_back(rx_byte);
            end
         end else if (TMO_EN && m_buf.size() != 0) begin
            m_tmo++;
            if (m_tmo >= TMO) begin err = 1; code = 3; m_buf.delete(); m_tmo = 0; end
         end
         fire = m_valid && ready;
         if (good) begin
            if (!m_valid || fire) begin m_valid = 1; m_op = p_op; m_data = d; end
            else m_overrun = 1;
         end else if (fire) m_valid = 0;
         m_pkt_err = err;
         if (err) m_code = code;
         if (err || m_overrun) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (go) begin
         chk("cmd_valid", {31'h0, o_cmd_valid}, {31'h0, m_valid});
         chk("pkt_err", {31'h0, o_pkt_err}, {31'h0, m_pkt_err});
         chk("overrun", {31'h0, o_overrun}, {31'h0, m_overrun});
         chk("err_cnt", {24'h0, o_err_cnt}, m_cnt);
         if (m_valid) begin
            chk("cmd_op", {24'h0, o_cmd_op}, {24'h0, m_op});
            chk("cmd_data", o_cmd_data, m_data);
         end
         if (m_pkt_err) chk("err_code", {30'h0, o_err_code}, {30'h0, m_code});
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte = b; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] op, input logic [31:0] data, input logic [7:0] cs);
      send(8'hA5); send(op);
      for (int i = 3; i >= 0; i--) send(data[8*i +: 8]);
      send(cs);
   endtask

   initial begin
      rst = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; ready = 1'b1;
      tick();
      go = 1'b1;
      tick();
      chk("rst_valid", {31'h0, o_cmd_valid}, 32'h0);
      chk("rst_op", {24'h0, o_cmd_op}, 32'h0);
      chk("rst_data", o_cmd_data, 32'h0);
      chk("rst_code", {30'h0, o_err_code}, 32'h0);
      chk("rst_cnt", {24'h0, o_err_cnt}, 32'h0);
      rst = 1'b0;
      tick();

      send(8'h33); send(8'h01);
      send_pkt(8'h01, 32'h12345678, 8'h09);
      chk("p1_valid", {31'h0, o_cmd_valid}, 32'h1);
      chk("p1_op", {24'h0, o_cmd_op}, 32'h01);
      chk("p1_data", o_cmd_data, 32'h12345678);
      tick();
      chk("p1_drop", {31'h0, o_cmd_valid}, 32'h0);

      send_pkt(8'h01, 32'h12345678, 8'h0A);
      chk("cs_err", {31'h0, o_pkt_err}, 32'h1);
      chk("cs_code", {30'h0, o_err_code}, {30'h0, ERR_CHECKSUM});
      chk("cs_cnt", {24'h0, o_err_cnt}, 32'd1);
      chk("cs_novalid", {31'h0, o_cmd_valid}, 32'h0);

      send(8'hA5); send(8'h7F);
      chk("op_err", {31'h0, o_pkt_err}, 32'h1);
      chk("op_code", {30'h0, o_err_code}, {30'h0, ERR_BAD_OP});
      send_pkt(8'h02, 32'h00000001, 8'h03);
      chk("p2_op", {24'h0, o_cmd_op}, 32'h02);
      chk("p2_data", o_cmd_data, 32'h1);
      tick();

      rx_err = 1'b1; tick(); rx_err = 1'b0;
      chk("idle_rxerr", {31'h0, o_pkt_err}, 32'h0);

      ready = 1'b0;
      send_pkt(8'h01, 32'h12345678, 8'h09);
      send_pkt(8'h02, 32'h00000001, 8'h03);
      chk("ovr_pulse", {31'h0, o_overrun}, 32'h1);
      chk("ovr_op", {24'h0, o_cmd_op}, 32'h01);
      chk("ovr_data", o_cmd_data, 32'h12345678);
      chk("ovr_cnt", {24'h0, o_err_cnt}, 32'd3);
      repeat (3) tick();
      ready = 1'b1; tick(); ready = 1'b0;
      chk("hs_drop", {31'h0, o_cmd_valid}, 32'h0);

      send_pkt(8'h01, 32'hCAFEF00D, 8'h01 ^ 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
      send(8'hA5); send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
      ready = 1'b1;
      send(8'h03);
      chk("same_cyc_valid", {31'h0, o_cmd_valid}, 32'h1);
      chk("same_cyc_op", {24'h0, o_cmd_op}, 32'h02);
      chk("same_cyc_ovr", {31'h0, o_overrun}, 32'h0);
      tick();

      send(8'hA5); send(8'h01); send(8'h12); send(8'h34);
      rx_byte = 8'h56; rx_valid = 1'b1; rx_err = 1'b1;
      tick();
      rx_valid = 1'b0; rx_err = 1'b0;
      chk("rx_err", {31'h0, o_pkt_err}, 32'h1);
      chk("rx_code", {30'h0, o_err_code}, {30'h0, ERR_RX});
      send_pkt(8'h01, 32'h12345678, 8'h09);
      chk("after_rx_valid", {31'h0, o_cmd_valid}, 32'h1);
      tick();

      send(8'hA5);
      repeat (TMO - 1) tick();
      chk("tmo_early", {31'h0, o_pkt_err}, 32'h0);
      tick();
      if (TMO_EN) begin
         chk("tmo_err", {31'h0, o_pkt_err}, 32'h1);
         chk("tmo_code", {30'h0, o_err_code}, {30'h0, ERR_TIMEOUT});
      end else begin
         chk("no_tmo", {31'h0, o_pkt_err}, 32'h0);
         repeat (10) tick();
         rx_err = 1'b1; tick(); rx_err = 1'b0;
         chk("abort_code", {30'h0, o_err_code}, {30'h0, ERR_RX});
      end

      for (int n = 0; n < 300; n++) send_pkt(8'h01, 32'h12345678, 8'h0A);
      tick();
      chk("sat_cnt", {24'h0, o_err_cnt}, 32'd255);

      ready = 1'b0;
      send_pkt(8'h02, 32'h00000001, 8'h03);
      send(8'hA5); send(8'h01); send(8'h12);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_valid", {31'h0, o_cmd_valid}, 32'h0);
      chk("mid_rst_op", {24'h0, o_cmd_op}, 32'h0);
      chk("mid_rst_data", o_cmd_data, 32'h0);
      chk("mid_rst_err", {31'h0, o_pkt_err}, 32'h0);
      chk("mid_rst_cnt", {24'h0, o_err_cnt}, 32'h0);
      ready = 1'b1;
      send(8'h34); send(8'h56);
      send_pkt(8'h02, 32'h00000001, 8'h03);
      chk("post_rst_valid", {31'h0, o_cmd_valid}, 32'h1);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
